// File: rtl/ntt_core_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : ntt_core_sequencer_if
// Description : Control/address bundle between the NTT sequencer and its core.
// Revision    : 1.0
// ============================================================================
interface ntt_core_sequencer_if #(
    parameter int ADDR_WIDTH = 9
);
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  stage_done;
    logic [3:0]            log_m;
    logic [1:0]            mode;
    logic [9:0]            i;
    logic [ADDR_WIDTH-1:0] read_address;
    logic                  upper_write_enable;
    logic                  lower_write_enable;
    logic [ADDR_WIDTH-1:0] upper_write_address;
    logic [ADDR_WIDTH-1:0] lower_write_address;

    modport master (
        input  start,
        output busy, done, stage_done, log_m, mode, i, read_address,
        output upper_write_enable, lower_write_enable,
        output upper_write_address, lower_write_address
    );

    modport slave (
        output start,
        input  busy, done, stage_done, log_m, mode, i, read_address,
        input  upper_write_enable, lower_write_enable,
        input  upper_write_address, lower_write_address
    );
endinterface
`default_nettype wire

// File: rtl/ntt_core_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ntt_core_sequencer
// Description : Steps one ntt_core through every NTT stage, issuing reads and
//               latency-matched in-place write-backs, draining between stages.
// Revision    : 1.0
// ============================================================================
module ntt_core_sequencer #(
    parameter int ADDR_WIDTH   = 9,
    parameter int DEPTH        = 512,
    parameter int NUM_STAGES   = 12,
    parameter int MODE1_START  = 5,
    parameter int MODE2_START  = 10,
    parameter int PIPE_LATENCY = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    ntt_core_sequencer_if.master  bus
);

    localparam int                    c_DW          = (PIPE_LATENCY > 1) ? $clog2(PIPE_LATENCY) : 1;
    localparam logic [c_DW-1:0]       c_DRAIN_LOAD  = c_DW'(PIPE_LATENCY - 1);
    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR   = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [3:0]            c_LAST_STAGE  = 4'(NUM_STAGES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    logic [c_DW-1:0]       r_drain_left;
    logic [ADDR_WIDTH-1:0] r_read_address;
    logic [3:0]            r_log_m;
    logic [1:0]            r_mode;
    logic [9:0]            r_i;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_stage_done;
    logic [PIPE_LATENCY-1:0] r_dl_valid;
    logic [ADDR_WIDTH-1:0]   r_dl_addr [PIPE_LATENCY];

    function automatic logic [1:0] mode_of(input logic [3:0] lm);
        if (int'(lm) < MODE1_START)      return 2'd0;
        else if (int'(lm) < MODE2_START) return 2'd1;
        else                             return 2'd2;
    endfunction

    function automatic logic [9:0] i_of(input logic [1:0] md, input logic [ADDR_WIDTH-1:0] a);
        logic [31:0] ext;
        ext = 32'(a);
        return (md == 2'd1) ? ext[9:0] : 10'd0;
    endfunction

    // r_drain_left counts the DRAIN cycles still to come after the current one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_drain_left   <= '0;
            r_read_address <= '0;
            r_log_m        <= 4'd0;
            r_mode         <= 2'd0;
            r_i            <= 10'd0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_stage_done   <= 1'b0;
        end else begin
            r_done       <= 1'b0;
            r_stage_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state        <= S_READ;
                        r_busy         <= 1'b1;
                        r_log_m        <= 4'd0;
                        r_mode         <= mode_of(4'd0);
                        r_read_address <= '0;
                        r_i            <= 10'd0;
                    end
                end
                S_READ: begin
                    if (r_read_address == c_LAST_ADDR) begin
                        r_state        <= S_DRAIN;
                        r_read_address <= '0;
                        r_i            <= 10'd0;
                        r_drain_left   <= c_DRAIN_LOAD;
                        r_stage_done   <= (PIPE_LATENCY == 1);
                    end else begin
                        r_read_address <= r_read_address + 1'b1;
                        r_i            <= i_of(r_mode, r_read_address + 1'b1);
                    end
                end
                S_DRAIN: begin
                    if (r_drain_left == '0) begin
                        if (r_log_m < c_LAST_STAGE) begin
                            r_state        <= S_READ;
                            r_log_m        <= r_log_m + 4'd1;
                            r_mode         <= mode_of(r_log_m + 4'd1);
                            r_read_address <= '0;
                            r_i            <= 10'd0;
                        end else begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_drain_left <= r_drain_left - 1'b1;
                        r_stage_done <= (r_drain_left == c_DW'(1));
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Write-back delay line: a read issued in cycle t lands in cycle t+PIPE_LATENCY
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dl_valid <= '0;
            for (int k = 0; k < PIPE_LATENCY; k++) r_dl_addr[k] <= '0;
        end else begin
            r_dl_valid[0] <= (r_state == S_READ);
            r_dl_addr[0]  <= r_read_address;
            for (int k = 1; k < PIPE_LATENCY; k++) begin
                r_dl_valid[k] <= r_dl_valid[k-1];
                r_dl_addr[k]  <= r_dl_addr[k-1];
            end
        end
    end

    assign bus.busy                = r_busy;
    assign bus.done                = r_done;
    assign bus.stage_done          = r_stage_done;
    assign bus.log_m               = r_log_m;
    assign bus.mode                = r_mode;
    assign bus.i                   = r_i;
    assign bus.read_address        = r_read_address;
    assign bus.upper_write_enable  = r_dl_valid[PIPE_LATENCY-1];
    assign bus.lower_write_enable  = r_dl_valid[PIPE_LATENCY-1];
    assign bus.upper_write_address = r_dl_addr[PIPE_LATENCY-1];
    assign bus.lower_write_address = r_dl_addr[PIPE_LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_ntt_core_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ntt_core_sequencer
// Description : Directed bench for ntt_core_sequencer, small and default configs.
// Revision    : 1.0
// ============================================================================
module tb_ntt_core_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    ntt_core_sequencer_if #(.ADDR_WIDTH(3)) bs ();
    ntt_core_sequencer_if #(.ADDR_WIDTH(9)) bd ();

    ntt_core_sequencer #(
        .ADDR_WIDTH(3), .DEPTH(8), .NUM_STAGES(3),
        .MODE1_START(1), .MODE2_START(2), .PIPE_LATENCY(4)
    ) dut_small (
        .clk (clk),
        .rst (rst),
        .bus (bs.master)
    );

    ntt_core_sequencer dut_def (
        .clk (clk),
        .rst (rst),
        .bus (bd.master)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        bs.start = 1'b0;
        bd.start = 1'b0;
        tick();
        tick();
        total++;
        if ({bs.busy, bs.done, bs.stage_done, bs.upper_write_enable, bs.lower_write_enable,
             bs.read_address, bs.log_m, bs.mode, bs.i} !== 24'd0) begin
            bad++;
            $display("FAIL reset_small obs=%h exp=0", {bs.busy, bs.done, bs.stage_done,
                     bs.read_address, bs.log_m, bs.mode, bs.i});
        end
        total++;
        if ({bd.busy, bd.done, bd.stage_done, bd.upper_write_enable, bd.lower_write_enable,
             bd.read_address, bd.log_m, bd.mode, bd.i} !== 30'd0) begin
            bad++;
            $display("FAIL reset_default obs=%h exp=0", {bd.busy, bd.done, bd.stage_done,
                     bd.read_address, bd.log_m, bd.mode, bd.i});
        end
        rst = 1'b0;
        tick();
    endtask

    // Expected timeline: 12 cycles per stage (8 reads + 4 drain), done at 37
    task automatic test_small_run;
        bs.start = 1'b1;
        tick();
        bs.start = 1'b0;
        for (int c = 1; c <= 38; c++) begin
            int s;
            int k;
            logic eb, ed, esd, ewe;
            logic [2:0] era, ewa;
            logic [9:0] ei;
            s   = (c - 1) / 12;
            k   = (c - 1) % 12;
            eb  = (c <= 36);
            ed  = (c == 37);
            esd = (c <= 36) && (k == 11);
            ewe = (c <= 36) && (k >= 4);
            era = ((c <= 36) && (k < 8)) ? 3'(k) : 3'd0;
            ewa = 3'(k - 4);
            ei  = ((c <= 36) && (s == 1) && (k < 8)) ? 10'(k) : 10'd0;
            total++;
            if ({bs.busy, bs.done, bs.stage_done, bs.upper_write_enable, bs.lower_write_enable,
                 bs.read_address, bs.i} !== {eb, ed, esd, ewe, ewe, era, ei}) begin
                bad++;
                $display("FAIL small_ctrl c=%0d obs=%b exp=%b", c,
                         {bs.busy, bs.done, bs.stage_done, bs.upper_write_enable,
                          bs.lower_write_enable, bs.read_address, bs.i},
                         {eb, ed, esd, ewe, ewe, era, ei});
            end
            if (ewe) begin
                total++;
                if ({bs.upper_write_address, bs.lower_write_address} !== {ewa, ewa}) begin
                    bad++;
                    $display("FAIL small_waddr c=%0d obs=%h/%h exp=%h", c,
                             bs.upper_write_address, bs.lower_write_address, ewa);
                end
            end
            if (c <= 36) begin
                total++;
                if ({bs.log_m, bs.mode} !== {4'(s), 2'(s)}) begin
                    bad++;
                    $display("FAIL small_stage c=%0d obs=%0d/%0d exp=%0d/%0d", c,
                             bs.log_m, bs.mode, s, s);
                end
            end
            if (c != 38) tick();
        end
    endtask

    task automatic test_start_held;
        int  n;
        bit  seen;
        bs.start = 1'b1;
        tick();
        for (int c = 1; c <= 39; c++) begin
            total++;
            if ({bs.busy, bs.done} !== {((c <= 36) || (c == 39)), (c == 37)}) begin
                bad++;
                $display("FAIL held_busy_done c=%0d obs=%b%b exp=%b%b", c, bs.busy, bs.done,
                         ((c <= 36) || (c == 39)), (c == 37));
            end
            if (c == 20 || c == 39) begin
                total++;
                if ({bs.read_address, bs.log_m} !== ((c == 20) ? {3'd7, 4'd1} : {3'd0, 4'd0})) begin
                    bad++;
                    $display("FAIL held_pos c=%0d obs=%0d/%0d", c, bs.read_address, bs.log_m);
                end
            end
            if (c != 39) tick();
        end
        bs.start = 1'b0;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 60) begin
            tick();
            n++;
            if (bs.done === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen || n != 36) begin
            bad++;
            $display("FAIL held_second_done obs=%0d cycles (seen=%0d) exp=36", n, seen);
        end
        tick();
    endtask

    task automatic test_reset_mid;
        bs.start = 1'b1;
        tick();
        bs.start = 1'b0;
        for (int c = 2; c <= 15; c++) tick();
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({bs.busy, bs.done, bs.stage_done, bs.upper_write_enable, bs.lower_write_enable,
             bs.read_address, bs.log_m, bs.mode, bs.i, bs.upper_write_address,
             bs.lower_write_address} !== 30'd0) begin
            bad++;
            $display("FAIL rst_async_clear obs=%h exp=0", {bs.busy, bs.done, bs.stage_done,
                     bs.upper_write_enable, bs.read_address, bs.log_m, bs.mode, bs.i});
        end
        tick();
        rst = 1'b0;
        for (int c = 16; c <= 20; c++) begin
            total++;
            if ({bs.upper_write_enable, bs.lower_write_enable, bs.busy} !== 3'b000) begin
                bad++;
                $display("FAIL rst_no_writes c=%0d obs=%b exp=000", c,
                         {bs.upper_write_enable, bs.lower_write_enable, bs.busy});
            end
            if (c != 20) tick();
        end
        bs.start = 1'b1;
        tick();
        bs.start = 1'b0;
        for (int c = 21; c <= 25; c++) begin
            total++;
            if ({bs.busy, bs.log_m, bs.read_address, bs.upper_write_enable, bs.lower_write_enable}
                !== {1'b1, 4'd0, 3'(c - 21), (c == 25), (c == 25)}) begin
                bad++;
                $display("FAIL rst_restart c=%0d obs=%b exp=%b", c,
                         {bs.busy, bs.log_m, bs.read_address, bs.upper_write_enable,
                          bs.lower_write_enable},
                         {1'b1, 4'd0, 3'(c - 21), (c == 25), (c == 25)});
            end
            if (c == 25) begin
                total++;
                if (bs.upper_write_address !== 3'd0) begin
                    bad++;
                    $display("FAIL rst_first_waddr obs=%0d exp=0", bs.upper_write_address);
                end
            end
            tick();
        end
    endtask

    // Defaults: 520 cycles per stage, writes at stage offsets 8..519 to address offset-8
    task automatic test_defaults;
        int n_sd, n_wr, n_done;
        n_sd = 0;
        n_wr = 0;
        n_done = 0;
        bd.start = 1'b1;
        tick();
        bd.start = 1'b0;
        for (int c = 1; c <= 6242; c++) begin
            int k;
            logic ewe, esd, ed;
            logic [8:0] ewa;
            k   = (c - 1) % 520;
            ewe = (c <= 6240) && (k >= 8);
            esd = (c <= 6240) && (k == 519);
            ed  = (c == 6241);
            ewa = ewe ? 9'(k - 8) : 9'd0;
            if (bd.stage_done === 1'b1) n_sd++;
            if (bd.upper_write_enable === 1'b1) n_wr++;
            if (bd.done === 1'b1) n_done++;
            total++;
            if ({bd.upper_write_enable, bd.lower_write_enable, bd.stage_done, bd.done,
                 bd.upper_write_enable ? bd.upper_write_address : 9'd0,
                 bd.lower_write_enable ? bd.lower_write_address : 9'd0}
                !== {ewe, ewe, esd, ed, ewa, ewa}) begin
                bad++;
                $display("FAIL def_cycle c=%0d obs we=%b%b sd=%b d=%b a=%0d/%0d exp we=%b sd=%b d=%b a=%0d",
                         c, bd.upper_write_enable, bd.lower_write_enable, bd.stage_done, bd.done,
                         bd.upper_write_address, bd.lower_write_address, ewe, esd, ed, ewa);
            end
            if (c != 6242) tick();
        end
        total++;
        if ({n_sd, n_wr, n_done} !== {32'd12, 32'd6144, 32'd1}) begin
            bad++;
            $display("FAIL def_totals obs sd=%0d wr=%0d done=%0d exp sd=12 wr=6144 done=1",
                     n_sd, n_wr, n_done);
        end
    endtask

    initial begin
        test_reset();
        test_small_run();
        test_start_held();
        test_reset_mid();
        test_defaults();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ntt_core_sequencer.md
Name: ntt_core_sequencer

Overview:
Sequences one ntt_core through a full forward NTT, stage by stage.
- Drives the core's stage index (log_m), twiddle mode, butterfly index i and BRAM read address.
- Generates matching write-back enables and addresses, delayed by the core's read-to-result pipeline latency.
- Drains the pipeline between stages so no stage reads a word before the previous stage's write to it has landed.
- Sits between the top-level NTT control FSM (start/done) and the per-core datapath; r1..r4 to data-input routing is owned by the interconnect.

Parameters:
ADDR_WIDTH, 9, BRAM address width.
DEPTH, 512, words per BRAM swept per stage.
NUM_STAGES, 12, number of stages; log_m runs 0..NUM_STAGES-1 (max 16).
MODE1_START, 5, first stage using mode 1.
MODE2_START, 10, first stage using mode 2.
PIPE_LATENCY, 8, cycles from read_address issue to valid r1..r4 (BRAM 2 + butterfly 6); must be ≥1.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  begin transform; sampled only in IDLE
busy  out  1  high in READ and DRAIN
done  out  1  one-cycle pulse after the final write of the final stage
stage_done  out  1  one-cycle pulse coincident with each stage's final write
log_m  out  4  current stage index
mode  out  2  twiddle addressing mode
i  out  10  butterfly index for mode 1
read_address  out  ADDR_WIDTH  shared BRAM read address
upper_write_enable  out  1  upper BRAM write strobe
lower_write_enable  out  1  lower BRAM write strobe
upper_write_address  out  ADDR_WIDTH  upper write address
lower_write_address  out  ADDR_WIDTH  lower write address

Behaviour:
- Reset (async, any state): state=IDLE. All outputs 0. Read counter, stage counter and delay-line valids/addresses cleared. In-flight writes are discarded, never emitted.
- All outputs are registered.
- States: IDLE, READ, DRAIN, DONE.
- IDLE:
  - start=1 at an edge -> READ; from the same edge log_m=0, read_address=0, busy=1.
  - start=0 -> stay in IDLE.
- READ:
  - read_address increments by 1 per cycle, 0..DEPTH-1.
  - After the cycle showing DEPTH-1 -> DRAIN; read_address returns to 0.
- DRAIN: lasts exactly PIPE_LATENCY cycles. Its last cycle carries the stage's final write and stage_done=1. Next state:
  - If log_m < NUM_STAGES-1: READ, with log_m+1 and read_address=0.
  - Otherwise: DONE.
- DONE: one cycle with done=1 and busy=0, then IDLE.
- start is ignored outside IDLE, including in DONE.
- Mode, combinational on log_m, registered alongside it:
  - log_m < MODE1_START -> 0.
  - log_m < MODE2_START -> 1.
  - otherwise -> 2.
  - Mode changes only at stage boundaries.
- i = zero-extended read_address when mode=1, else 0; same cycle as read_address.
- Write-back delay line:
  - A PIPE_LATENCY-deep shift register of {valid, address}.
  - valid=1 is loaded for each READ cycle; in all other states valid=0.
  - The write for the address issued in cycle t appears in cycle t+PIPE_LATENCY.
  - Both write enables = delayed valid; both write addresses = delayed address (in-place update).
- Write enables are never asserted in IDLE or DONE, or in READ cycles before the first PIPE_LATENCY reads of a stage.
- Cycles per stage = DEPTH + PIPE_LATENCY; done appears NUM_STAGES*(DEPTH+PIPE_LATENCY)+1 cycles after the start edge.
- No read of a stage precedes the final write of the previous stage.

Test Plan:
- Overrides DEPTH=8, PIPE_LATENCY=4, NUM_STAGES=3, MODE1_START=1, MODE2_START=2; start pulsed at cycle 0 -> read_address 0..7 in cycles 1..8. Writes to addresses 0..7 in cycles 5..12. stage_done at 12. Stage 1 reads in cycles 13..20. done=1 at cycle 37 only; busy low from 37.
- Same run -> mode=0/log_m=0 in cycles 1..12, mode=1/log_m=1 in cycles 13..24, mode=2/log_m=2 in cycles 25..36. i equals read_address only in cycles 13..20, 0 elsewhere.
- start held high continuously -> exactly one transform per IDLE entry. Second run begins the cycle after DONE (start seen in IDLE at cycle 38); no restart mid-run.
- rst asserted at cycle 15 (mid stage 1, writes pending) -> same-cycle async clear: all outputs 0, no further writes. start at cycle 20 -> clean stage-0 run from read_address 0.
- Defaults (DEPTH=512, PIPE_LATENCY=8, NUM_STAGES=12) -> 12 stage_done pulses, 520 cycles apart. 6144 write strobes total, each address 0..511 written exactly once per stage. done at cycle 6241.
